// File: rtl/j1_io_xbar.sv
// J1 CPU I/O crossbar: routes rd/wr to NSLOT peripheral pages and serves a status register at 16'hFF00.
// Define J1_IO_TIMEOUT_EN to abort accesses that get no ack within TIMEOUT cycles.
module j1_io_xbar #(
  parameter int          NSLOT     = 4,
  parameter logic [7:0]  SLOT_BASE = 8'h67,
  parameter logic [15:0] DFLT_DATA = 16'h0666,
  parameter int          TIMEOUT   = 15
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  input  logic               j1_io_rd,
  input  logic               j1_io_wr,
  input  logic [15:0]        j1_io_addr,
  input  logic [15:0]        j1_io_dout,
  output logic [15:0]        j1_io_din,
  output logic               j1_io_stall,
  output logic [NSLOT-1:0]   cs,
  output logic [7:0]         per_addr,
  output logic [15:0]        per_dout,
  output logic               per_rd,
  output logic               per_wr,
  input  logic [NSLOT*16-1:0] per_din,
  input  logic [NSLOT-1:0]   per_ack
);
  localparam int         SW     = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [7:0] NSLOT8 = 8'(NSLOT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nxt;

  logic          start, mapped, is_stat_reg, op_wr, sel_ack, tmo_hit;
  logic [7:0]    page_off;
  logic [SW-1:0] slot_q;
  logic [15:0]   sel_din, stat_val;

  // Page offset wraps modulo 256, so pages below SLOT_BASE land far above NSLOT.
  assign page_off    = j1_io_addr[15:8] - SLOT_BASE;
  assign mapped      = (j1_io_addr[15:8] != 8'hFF) && (page_off < NSLOT8);
  assign is_stat_reg = (j1_io_addr == 16'hFF00);
  assign start       = (state == IDLE) && (j1_io_rd || j1_io_wr);
  assign sel_ack     = per_ack[slot_q];
  assign sel_din     = per_din[{slot_q, 4'b0000} +: 16];

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    j1_io_stall = 1'b0;
    cs          = '0;
    per_rd      = 1'b0;
    per_wr      = 1'b0;
    case (state)
      IDLE: begin
        if (j1_io_rd || j1_io_wr) begin
          j1_io_stall = 1'b1;
          state_nxt   = mapped ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        j1_io_stall = 1'b1;
        cs          = NSLOT'(1) << slot_q;
        per_rd      = !op_wr;
        per_wr      = op_wr;
        if (sel_ack || tmo_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A request held across reset must not show up as a stall.
    if (!sys_rst_i) j1_io_stall = 1'b0;
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      per_addr  <= '0;
      per_dout  <= '0;
      op_wr     <= 1'b0;
      slot_q    <= '0;
      j1_io_din <= DFLT_DATA;
    end else begin
      if (start) begin
        per_addr <= j1_io_addr[7:0];
        per_dout <= j1_io_dout;
        op_wr    <= j1_io_wr;
        slot_q   <= page_off[SW-1:0];
        if (!mapped && !j1_io_wr) j1_io_din <= is_stat_reg ? stat_val : DFLT_DATA;
      end
      if (state == ACCESS && !op_wr) begin
        if (sel_ack)      j1_io_din <= sel_din;
        else if (tmo_hit) j1_io_din <= DFLT_DATA;
      end
    end
  end

`ifdef J1_IO_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt, stat_cnt;
  logic [3:0] stat_slot;
  logic       stat_clr;

  assign tmo_hit  = (state == ACCESS) && !sel_ack && (tmo_cnt == TMO_LAST);
  assign stat_clr = start && j1_io_wr && is_stat_reg;
  assign stat_val = {stat_cnt, 4'h0, stat_slot};

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i)                             tmo_cnt <= '0;
    else if (state == IDLE)                     tmo_cnt <= '0;
    else if (state == ACCESS)                   tmo_cnt <= tmo_cnt + 8'd1;
  end

  // Timeout wins over a coincident clear, counting from zero.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      stat_cnt  <= '0;
      stat_slot <= '0;
    end else if (tmo_hit) begin
      stat_cnt  <= stat_clr ? 8'd1 : ((stat_cnt == 8'hFF) ? stat_cnt : stat_cnt + 8'd1);
      stat_slot <= 4'(slot_q);
    end else if (stat_clr) begin
      stat_cnt  <= '0;
      stat_slot <= '0;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign stat_val = 16'h0000;
`endif

endmodule
